mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit for the RV M-extension; the next generation of the single-opcode MULT_OP path.
- Decodes the full M-extension func3 space: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Runs one radix-2 iteration per clock.
- Sits beside the ALU in EX. The control unit selects it when func7[0]=1 on an R-type op, and holds the pipeline stalled while busy=1.

Parameters:
- WIDTH, 64, operand/result width in bits; must be >= 4 and a power of two.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- flush  input  1  synchronous abort from pipeline flush; priority over start.
- func3  input  3  M-extension func3; latched on accepted start.
- op_a  input  WIDTH  rs1 value (multiplicand/dividend); latched on accepted start.
- op_b  input  WIDTH  rs2 value (multiplier/divisor); latched on accepted start.
- busy  output  1  high in CALC and FIX; the pipeline stalls on it.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all datapath registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0 (accepted start):
  - Latch func3 and operands.
  - Signedness: a is signed for func3 001/010/100/110; b is signed for 001/100/110.
  - Store magnitudes and the result-sign flags.
  - Go to CALC with counter=WIDTH, unless a divide special case applies; then go directly to DONE.
- Divide special cases (func3[2]=1), per the RISC-V spec:
  - b==0: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a = most-negative value, op_b = -1, func3 100/110): quotient = op_a; remainder = 0.
- CALC, multiply: shift-add on a 2*WIDTH product register, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- Counter decrements each CALC cycle; counter reaching 0 moves the FSM to FIX.
- FIX (one cycle): apply two's-complement sign correction.
  - Product negated when sign_a^sign_b.
  - Quotient negated when sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - Select the output: MUL = low WIDTH bits; MULH/MULHSU/MULHU = high WIDTH bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selection into result, then go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. Back-to-back: a start in the DONE cycle is ignored; a new start is accepted in the following IDLE cycle.
- Latency:
  - Normal op: start accepted at edge T0, done high during the cycle after edge T0+WIDTH+2, so WIDTH+2 busy cycles.
  - Special-case divide: done high in the cycle after edge T0, no busy cycles.
- Control rules:
  - busy is low in IDLE and DONE.
  - start while busy is ignored, and the latched operands are unaffected.
- flush=1 in any state: next state IDLE, no done pulse; result keeps its previous value; counter cleared. flush and start together in IDLE: flush wins, nothing is launched.
- Asynchronous reset mid-operation: immediate IDLE; no done pulse after release.
- Undefined func3 cannot occur, since all 8 codes are defined.

Test Plan:
- WIDTH=64, MUL, a=7, b=-3 -> busy high 66 cycles; done=1 for one cycle; result=0xFFFF_FFFF_FFFF_FFEB (-21).
- WIDTH=64, MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. Same operands with MULH -> result=0.
- WIDTH=64, DIV a=-7 b=2 -> result=-3. REM with the same operands -> result=-1. DIVU a=100 b=7 -> 14. REMU -> 2.
- WIDTH=64, DIV a=5 b=0 -> done in the cycle after start, busy never high, result=all ones. REM a=5 b=0 -> result=5. DIV a=0x8000_0000_0000_0000 b=-1 -> result=0x8000_0000_0000_0000. REM with the same operands -> result=0.
- WIDTH=8, DIVU a=200 b=3:
  - flush at cycle 4 of CALC -> IDLE next cycle, no done, result unchanged.
  - Restart with a=200 b=3 -> result=66 after 10 busy cycles.
  - start pulses during busy are ignored.
- WIDTH=8, MUL in progress, arst_n pulled low for 3 ns mid-CALC -> busy=0, done=0, result=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/mdu_iterative.sv
// ---------------------------------------------------------------------------
// mdu_iterative
//
// Multi-cycle multiply/divide unit covering the full RV M-extension func3
// space (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). Operands are
// converted to magnitudes on launch. One radix-2 step runs per clock:
// shift-add for multiply, restoring division for divide. A single fix-up
// cycle then restores the signs and selects the requested half or result.
//
// Ports:
//   clk     rising-edge clock
//   arst_n  asynchronous active-low reset
//   start   launch request, sampled only while idle
//   flush   synchronous abort; overrides start
//   func3   M-extension func3, latched on an accepted start
//   op_a    rs1 (multiplicand / dividend), latched on an accepted start
//   op_b    rs2 (multiplier / divisor), latched on an accepted start
//   busy    high while iterating or fixing up; the pipeline stalls on it
//   done    one-cycle pulse; result is valid in that cycle
//   result  registered result, held until the next completed operation
// ---------------------------------------------------------------------------
module mdu_iterative #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic en);
    return en ? -x : x;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         func3_q, func3_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Launch decode: signedness, magnitudes and divide special cases.
  logic             a_signed, b_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;

  assign a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                    (func3 == 3'b100) || (func3 == 3'b110);
  assign b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
  assign sign_a   = a_signed & op_a[WIDTH-1];
  assign sign_b   = b_signed & op_b[WIDTH-1];
  assign mag_a    = cond_neg(op_a, sign_a);
  assign mag_b    = cond_neg(op_b, sign_b);
  assign div_zero = func3[2] && (op_b == '0);
  // Only the signed divide/remainder codes (100, 110) can overflow.
  assign div_ovf  = func3[2] && !func3[0] && (op_a == MIN_VAL) && (op_b == '1);

  // Iteration step. acc_q is {high, low}: for multiply the high half is the
  // running partial product and the low half the remaining multiplier bits;
  // for divide the high half is the partial remainder and the low half
  // shifts dividend bits out while quotient bits shift in.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next  = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  // A borrow out of the trial subtraction means the divisor did not fit:
  // keep the shifted remainder (restore) and shift in a zero quotient bit.
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Fix-up: sign correction and output selection.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_sel;

  assign prod_fix = cond_neg_2w(acc_q, neg_res_q);
  assign quot_fix = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix  = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  always_comb begin
    fix_sel = '0;
    case (func3_q)
      3'b000:                 fix_sel = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_sel = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_sel = quot_fix;
      default:                fix_sel = rem_fix;
    endcase
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            func3_d   = func3;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            if (div_zero) begin
              result_d = func3[1] ? op_a : '1;
              cnt_d    = '0;
              state_d  = DONE;
            end else if (div_ovf) begin
              result_d = func3[1] ? '0 : op_a;
              cnt_d    = '0;
              state_d  = DONE;
            end else begin
              if (func3[2]) begin
                opnd_d = mag_b;
                acc_d  = {{WIDTH{1'b0}}, mag_a};
              end else begin
                opnd_d = mag_a;
                acc_d  = {{WIDTH{1'b0}}, mag_b};
              end
              cnt_d   = CNT_W'(WIDTH);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          // The iteration count is spent on WIDTH steps; the cycle that
          // sees zero only hands over to the fix-up.
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            acc_d = func3_q[2] ? div_next : mul_next;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          result_d = fix_sel;
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      func3_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;

  logic        clk;
  logic        arst_n;

  logic        start64, flush64, busy64, done64;
  logic [2:0]  f64;
  logic [63:0] a64, b64, res64;

  logic        start8, flush8, busy8, done8;
  logic [2:0]  f8;
  logic [7:0]  a8, b8, res8;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  mdu_iterative #(.WIDTH(64)) dut64 (
    .clk(clk), .arst_n(arst_n), .start(start64), .flush(flush64),
    .func3(f64), .op_a(a64), .op_b(b64),
    .busy(busy64), .done(done64), .result(res64)
  );

  mdu_iterative #(.WIDTH(8)) dut8 (
    .clk(clk), .arst_n(arst_n), .start(start8), .flush(flush8),
    .func3(f8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .result(res8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model built on native arithmetic.
  function automatic logic [63:0] ref64(input logic [2:0] f, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up;
    logic signed [63:0]  sa, sb, sq;
    logic                ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN64) && (b == ALL1);
    sp  = '0;
    up  = '0;
    sq  = '0;
    ref64 = '0;
    case (f)
      3'b000: begin up = {64'd0, a} * {64'd0, b}; ref64 = up[63:0]; end
      3'b001: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); ref64 = sp[127:64]; end
      3'b010: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); ref64 = sp[127:64]; end
      3'b011: begin up = {64'd0, a} * {64'd0, b}; ref64 = up[127:64]; end
      3'b100: begin
        if (b == '0) ref64 = ALL1;
        else if (ovf) ref64 = a;
        else begin sq = sa / sb; ref64 = sq; end
      end
      3'b101: ref64 = (b == '0) ? ALL1 : a / b;
      3'b110: begin
        if (b == '0) ref64 = a;
        else if (ovf) ref64 = '0;
        else begin sq = sa % sb; ref64 = sq; end
      end
      default: ref64 = (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic issue64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    f64 = f; a64 = a; b64 = b; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    f8 = f; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait64(input int budget, output bit seen, output int nb, output logic [63:0] r);
    seen = 1'b0; nb = 0; r = '0;
    for (int i = 0; i < budget; i++) begin
      if (done64) begin seen = 1'b1; r = res64; break; end
      if (busy64) nb++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait8(input int budget, output bit seen, output int nb, output logic [7:0] r);
    seen = 1'b0; nb = 0; r = '0;
    for (int i = 0; i < budget; i++) begin
      if (done8) begin seen = 1'b1; r = res8; break; end
      if (busy8) nb++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    start64 = 0; flush64 = 0; f64 = '0; a64 = '0; b64 = '0;
    start8 = 0;  flush8 = 0;  f8 = '0;  a8 = '0;  b8 = '0;
    #12;
    checks++;
    if (busy64 !== 1'b0 || done64 !== 1'b0 || res64 !== 64'd0) begin
      failures++;
      $display("FAIL reset64 busy=%b done=%b result=%h required 0/0/0", busy64, done64, res64);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0) begin
      failures++;
      $display("FAIL reset8 busy=%b done=%b result=%h required 0/0/0", busy8, done8, res8);
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    vec_t tbl[5];
    bit seen; int nb; logic [63:0] r, e;
    tbl[0] = '{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{3'b011, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2] = '{3'b001, ALL1, ALL1, 64'd0};
    tbl[3] = '{3'b010, ALL1, 64'd2, ALL1};
    tbl[4] = '{3'b001, MIN64, MIN64, 64'h4000_0000_0000_0000};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tbl[i].e);
      issue64(tbl[i].f, tbl[i].a, tbl[i].b);
      wait64(100, seen, nb, r);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin failures++; $display("FAIL mul_timeout[%0d] done not seen required within 100 cycles", i); end
      checks++;
      if (r !== e) begin failures++; $display("FAIL mul_result[%0d] got=%h required=%h", i, r, e); end
      checks++;
      if (nb != 66) begin failures++; $display("FAIL mul_busy_cycles[%0d] got=%0d required=66", i, nb); end
      @(posedge clk); #1;
      checks++;
      if (done64 !== 1'b0 || busy64 !== 1'b0) begin
        failures++; $display("FAIL mul_done_width[%0d] done=%b busy=%b required 0/0", i, done64, busy64);
      end
    end
  endtask

  task automatic test_div;
    vec_t tbl[7];
    bit seen; int nb; logic [63:0] r, e;
    tbl[0] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[1] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1};
    tbl[2] = '{3'b101, 64'd100, 64'd7, 64'd14};
    tbl[3] = '{3'b111, 64'd100, 64'd7, 64'd2};
    tbl[4] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[5] = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    tbl[6] = '{3'b101, MIN64, ALL1, 64'd0};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i].e);
      issue64(tbl[i].f, tbl[i].a, tbl[i].b);
      wait64(100, seen, nb, r);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin failures++; $display("FAIL div_timeout[%0d] done not seen required within 100 cycles", i); end
      checks++;
      if (r !== e) begin failures++; $display("FAIL div_result[%0d] got=%h required=%h", i, r, e); end
      checks++;
      if (nb != 66) begin failures++; $display("FAIL div_busy_cycles[%0d] got=%0d required=66", i, nb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_special;
    vec_t tbl[6];
    bit seen; int nb; logic [63:0] r, e;
    tbl[0] = '{3'b100, 64'd5, 64'd0, ALL1};
    tbl[1] = '{3'b110, 64'd5, 64'd0, 64'd5};
    tbl[2] = '{3'b100, MIN64, ALL1, MIN64};
    tbl[3] = '{3'b110, MIN64, ALL1, 64'd0};
    tbl[4] = '{3'b101, 64'd5, 64'd0, ALL1};
    tbl[5] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(tbl[i].e);
      issue64(tbl[i].f, tbl[i].a, tbl[i].b);
      // Done must be up in the very cycle after the accepting edge.
      checks++;
      if (done64 !== 1'b1 || busy64 !== 1'b0) begin
        failures++; $display("FAIL special_latency[%0d] done=%b busy=%b required 1/0", i, done64, busy64);
      end
      wait64(5, seen, nb, r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin failures++; $display("FAIL special_result[%0d] got=%h required=%h", i, r, e); end
      @(posedge clk); #1;
      checks++;
      if (done64 !== 1'b0 || busy64 !== 1'b0) begin
        failures++; $display("FAIL special_done_width[%0d] done=%b busy=%b required 0/0", i, done64, busy64);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] f; logic [63:0] a, b, r, e;
    bit seen; int nb; int lat;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (i % 4 == 1) b = 64'($urandom_range(0, 3));
      if (i % 5 == 2) a = -64'($urandom_range(1, 1000));
      if (i == 7) begin f = 3'b110; a = MIN64; b = ALL1; end
      lat = (f[2] && ((b == '0) || (!f[0] && a == MIN64 && b == ALL1))) ? 0 : 66;
      exp_q.push_back(ref64(f, a, b));
      issue64(f, a, b);
      wait64(100, seen, nb, r);
      e = exp_q.pop_front();
      checks++;
      if (!seen || r !== e) begin
        failures++;
        $display("FAIL rand_result[%0d] f=%0d a=%h b=%h got=%h required=%h seen=%b", i, f, a, b, r, e, seen);
      end
      checks++;
      if (nb != lat) begin failures++; $display("FAIL rand_busy[%0d] got=%0d required=%0d", i, nb, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_start;
    logic [63:0] prev;
    int nd;
    prev = res64;
    f64 = 3'b101; a64 = 64'd9; b64 = 64'd3;
    start64 = 1'b1; flush64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0; flush64 = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done64 || busy64) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL flush_start_launch active_cycles=%0d required=0", nd); end
    checks++;
    if (res64 !== prev) begin failures++; $display("FAIL flush_start_result got=%h required=%h", res64, prev); end
  endtask

  task automatic test_back_to_back;
    bit seen; int nb; logic [63:0] r, e;
    exp_q.push_back(64'd14);
    issue64(3'b101, 64'd100, 64'd7);
    wait64(100, seen, nb, r);
    e = exp_q.pop_front();
    checks++;
    if (!seen || r !== e) begin failures++; $display("FAIL b2b_first got=%h required=%h seen=%b", r, e, seen); end
    // Hold start from the DONE cycle into the following IDLE cycle.
    exp_q.push_back(64'd2);
    f64 = 3'b111; a64 = 64'd100; b64 = 64'd7; start64 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy64 !== 1'b0 || done64 !== 1'b0) begin
      failures++; $display("FAIL b2b_done_start busy=%b done=%b required 0/0", busy64, done64);
    end
    @(posedge clk); #1;
    start64 = 1'b0;
    checks++;
    if (busy64 !== 1'b1) begin failures++; $display("FAIL b2b_idle_start busy=%b required 1", busy64); end
    wait64(100, seen, nb, r);
    e = exp_q.pop_front();
    checks++;
    if (!seen || r !== e) begin failures++; $display("FAIL b2b_second got=%h required=%h seen=%b", r, e, seen); end
    checks++;
    if (nb != 66) begin failures++; $display("FAIL b2b_busy got=%0d required=66", nb); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush8;
    bit seen; int nb, nd; logic [7:0] r; logic [63:0] e;
    exp_q.push_back(64'd14);
    issue8(3'b101, 8'd100, 8'd7);
    wait8(30, seen, nb, r);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {56'd0, r} !== e) begin failures++; $display("FAIL w8_divu got=%h required=%h seen=%b", r, e[7:0], seen); end
    checks++;
    if (nb != 10) begin failures++; $display("FAIL w8_busy got=%0d required=10", nb); end
    @(posedge clk); #1;
    issue8(3'b101, 8'd200, 8'd3);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    flush8 = 1'b1;
    @(posedge clk); #1;
    flush8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd14) begin
      failures++; $display("FAIL w8_flush busy=%b done=%b result=%h required 0/0/0e", busy8, done8, res8);
    end
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (done8 || busy8) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL w8_flush_after active_cycles=%0d required=0", nd); end
  endtask

  task automatic test_restart8;
    bit seen; int nb, pre; logic [7:0] r; logic [63:0] e;
    exp_q.push_back(64'd66);
    issue8(3'b101, 8'd200, 8'd3);
    pre = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy8) pre++;
      f8 = 3'b000; a8 = 8'd9; b8 = 8'd2; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    wait8(30, seen, nb, r);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {56'd0, r} !== e) begin failures++; $display("FAIL w8_restart got=%h required=%h seen=%b", r, e[7:0], seen); end
    checks++;
    if (pre + nb != 10) begin failures++; $display("FAIL w8_restart_busy got=%0d required=10", pre + nb); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int nd;
    issue8(3'b000, 8'd5, 8'd6);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0) begin
      failures++; $display("FAIL arst_mid busy=%b done=%b result=%h required 0/0/00", busy8, done8, res8);
    end
    #2;
    arst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) nd++;
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL arst_after active_cycles=%0d required=0", nd); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_random();
    test_flush_start();
    test_back_to_back();
    test_flush8();
    test_restart8();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
